// File: rtl/cntr_step_gen_pkg.sv
// Shared definitions for the counter step generator: debounce FSM state
// encodings and the default board clock rate.
package cntr_step_gen_pkg;

    // Debounce FSM states; the encoding is fixed so checkers can bind to it.
    typedef enum logic [1:0] {
        ST_IDLE         = 2'd0,
        ST_PRESS_WAIT   = 2'd1,
        ST_PRESSED      = 2'd2,
        ST_RELEASE_WAIT = 2'd3
    } state_t;

    // DE1-SoC system clock rate.
    localparam int CLK_HZ = 50000000;

endpackage

// File: rtl/cntr_step_gen_sync2.sv
// Two-flop synchroniser for a single asynchronous level, with an
// asynchronous active-low reset to a parameterised idle value.
module sync2 #(
    parameter logic RST_VAL = 1'b0
) (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic q
);

    logic meta;

    // Two-stage capture; the first stage may go metastable, the second settles it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta <= RST_VAL;
            q    <= RST_VAL;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/cntr_step_gen.sv
// Count-enable pulse generator for the 4-bit counter. Produces a single-cycle
// cin pulse either per debounced button press (button mode) or once every
// PRESCALE_DIV cycles (auto mode). hold suppresses pulses and freezes the
// prescaler. The debounce FSM state is exported on dbg_state for checkers.
module cntr_step_gen
    import cntr_step_gen_pkg::*;
#(
    parameter int PRESCALE_DIV    = CLK_HZ,
    parameter int DEBOUNCE_CYCLES = 1000000
) (
    input  logic   clk,
    input  logic   rst_n,
    input  logic   key_n,
    input  logic   auto_en,
    input  logic   hold,
    output logic   cin,
    output logic   key_level,
    output state_t dbg_state
);

    localparam int DCW = $clog2(DEBOUNCE_CYCLES + 1);
    localparam int PCW = $clog2(PRESCALE_DIV);
    localparam logic [DCW-1:0] DB_LAST = DCW'(DEBOUNCE_CYCLES - 1);
    localparam logic [PCW-1:0] PS_LAST = PCW'(PRESCALE_DIV - 1);

    logic           ks;           // synchronised key_n (1 = released)
    logic           as;           // synchronised auto_en
    state_t         state_q, state_d;
    logic [DCW-1:0] cnt_q, cnt_d;
    logic           key_level_d;
    logic           press_evt;
    logic [PCW-1:0] ps_q, ps_d;
    logic           tick;
    logic           cin_d;

    // Button idles released (high), so its synchroniser resets to 1.
    sync2 #(.RST_VAL(1'b1)) u_sync_key (
        .clk   (clk),
        .rst_n (rst_n),
        .d     (key_n),
        .q     (ks)
    );

    // Mode switch resets to button mode.
    sync2 #(.RST_VAL(1'b0)) u_sync_auto (
        .clk   (clk),
        .rst_n (rst_n),
        .d     (auto_en),
        .q     (as)
    );

    // Debounce FSM state, stability counter and debounced level registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_IDLE;
            cnt_q     <= '0;
            key_level <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            key_level <= key_level_d;
        end
    end

    // Debounce next-state: a level change is accepted only after
    // DEBOUNCE_CYCLES consecutive samples of the new level. Runs independent
    // of mode and hold so key_level always follows the button.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        key_level_d = key_level;
        press_evt   = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                if (!ks) begin
                    state_d = ST_PRESS_WAIT;
                    cnt_d   = '0;
                end
            end
            ST_PRESS_WAIT: begin
                if (ks) begin
                    state_d = ST_IDLE;
                    cnt_d   = '0;
                end else if (cnt_q == DB_LAST) begin
                    state_d     = ST_PRESSED;
                    key_level_d = 1'b1;
                    press_evt   = 1'b1;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            ST_PRESSED: begin
                if (ks) begin
                    state_d = ST_RELEASE_WAIT;
                    cnt_d   = '0;
                end
            end
            ST_RELEASE_WAIT: begin
                if (!ks) begin
                    state_d = ST_PRESSED;
                    cnt_d   = '0;
                end else if (cnt_q == DB_LAST) begin
                    state_d     = ST_IDLE;
                    key_level_d = 1'b0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: begin
                state_d = ST_IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    // Prescaler next count: cleared outside auto mode so re-enabling starts a
    // full period; frozen under hold; wraps after the terminal tick.
    always_comb begin
        tick = 1'b0;
        ps_d = ps_q;
        if (!as) begin
            ps_d = '0;
        end else if (!hold) begin
            if (ps_q == PS_LAST) begin
                tick = 1'b1;
                ps_d = '0;
            end else begin
                ps_d = ps_q + 1'b1;
            end
        end
    end

    // Prescaler count register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ps_q <= '0;
        end else begin
            ps_q <= ps_d;
        end
    end

    // Exclusive source select; a press seen in auto mode or under hold is dropped.
    always_comb begin
        cin_d = !hold && ((as && tick) || (!as && press_evt));
    end

    // Registered count-enable output.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cin <= 1'b0;
        end else begin
            cin <= cin_d;
        end
    end

    assign dbg_state = state_q;

endmodule

// File: tb/tb_cntr_step_gen.sv
// Directed bench for cntr_step_gen with PRESCALE_DIV=5, DEBOUNCE_CYCLES=4.
// Cycle index cyc names the clock edge that samples the inputs driven just
// before it; outputs are sampled 1 ns after that edge.
module tb_cntr_step_gen;
  import cntr_step_gen_pkg::*;

  logic   clk;
  logic   rst_n;
  logic   key_n;
  logic   auto_en;
  logic   hold;
  logic   cin;
  logic   key_level;
  state_t dbg_state;

  int n_checks;
  int n_pass;

  cntr_step_gen #(
    .PRESCALE_DIV    (5),
    .DEBOUNCE_CYCLES (4)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .key_n     (key_n),
    .auto_en   (auto_en),
    .hold      (hold),
    .cin       (cin),
    .key_level (key_level),
    .dbg_state (dbg_state)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reset for two edges, release between edges; the next edge is cyc 1.
  task automatic apply_reset(input logic a);
    rst_n   = 1'b0;
    key_n   = 1'b1;
    auto_en = a;
    hold    = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
  endtask

  task automatic settle_release();
    key_n = 1'b1;
    hold  = 1'b0;
    for (int i = 0; i < 10; i++) tick();
  endtask

  // Reset with random inputs, then auto mode: pulses at 7, 12, ... 52.
  task automatic test_reset();
    int npulse;
    logic exp_cin;
    rst_n = 1'b0;
    for (int i = 0; i < 6; i++) begin
      key_n   = 1'($urandom_range(0, 1));
      auto_en = 1'($urandom_range(0, 1));
      hold    = 1'($urandom_range(0, 1));
      tick();
      n_checks++;
      if (cin !== 1'b0) $display("FAIL reset_cin i=%0d got=%b want=0", i, cin);
      else n_pass++;
      n_checks++;
      if (key_level !== 1'b0) $display("FAIL reset_key_level i=%0d got=%b want=0", i, key_level);
      else n_pass++;
    end
    key_n   = 1'b1;
    auto_en = 1'b1;
    hold    = 1'b0;
    rst_n   = 1'b1;
    npulse  = 0;
    for (int cyc = 1; cyc <= 53; cyc++) begin
      tick();
      exp_cin = (cyc >= 7) && (((cyc - 7) % 5) == 0);
      if (cin === 1'b1) npulse++;
      n_checks++;
      if (cin !== exp_cin) $display("FAIL auto_period cyc=%0d got=%b want=%b", cyc, cin, exp_cin);
      else n_pass++;
    end
    n_checks++;
    if (npulse != 10) $display("FAIL auto_pulse_count got=%0d want=10", npulse);
    else n_pass++;
  endtask

  // Clean press held 20 cycles in button mode, then release.
  task automatic test_clean_press();
    apply_reset(1'b0);
    for (int cyc = 1; cyc <= 32; cyc++) begin
      key_n = (cyc <= 20) ? 1'b0 : 1'b1;
      tick();
      n_checks++;
      if (cin !== (cyc == 7)) $display("FAIL press_cin cyc=%0d got=%b want=%b", cyc, cin, (cyc == 7));
      else n_pass++;
      if (cyc == 5) begin
        n_checks++;
        if (key_level !== 1'b0) $display("FAIL press_level_early got=%b want=0", key_level);
        else n_pass++;
      end
      if (cyc == 7 || cyc == 26) begin
        n_checks++;
        if (key_level !== 1'b1) $display("FAIL press_level_high cyc=%0d got=%b want=1", cyc, key_level);
        else n_pass++;
      end
      if (cyc == 27) begin
        n_checks++;
        if (key_level !== 1'b0) $display("FAIL release_level got=%b want=0", key_level);
        else n_pass++;
      end
    end
  endtask

  // Five 3-low/1-high bounces then a 10-cycle low run starting at cyc 21.
  task automatic test_bounce();
    apply_reset(1'b0);
    for (int cyc = 1; cyc <= 30; cyc++) begin
      if (cyc <= 20) key_n = (((cyc - 1) % 4) == 3);
      else key_n = 1'b0;
      tick();
      n_checks++;
      if (cin !== (cyc == 27)) $display("FAIL bounce_cin cyc=%0d got=%b want=%b", cyc, cin, (cyc == 27));
      else n_pass++;
    end
    settle_release();
  endtask

  // Auto mode, hold for 12 cycles with the prescaler at 2: it resumes there.
  task automatic test_hold();
    logic exp_cin;
    apply_reset(1'b1);
    for (int cyc = 1; cyc <= 30; cyc++) begin
      hold = (cyc >= 10 && cyc <= 21);
      tick();
      exp_cin = (cyc == 7) || (cyc >= 24 && ((cyc - 24) % 5) == 0);
      n_checks++;
      if (cin !== exp_cin) $display("FAIL hold_cin cyc=%0d got=%b want=%b", cyc, cin, exp_cin);
      else n_pass++;
    end
    hold = 1'b0;
  endtask

  // Hold asserted exactly when the press completes: pulse lost, not deferred.
  task automatic test_hold_press();
    apply_reset(1'b0);
    for (int cyc = 1; cyc <= 16; cyc++) begin
      key_n = 1'b0;
      hold  = (cyc == 7);
      tick();
      n_checks++;
      if (cin !== 1'b0) $display("FAIL hold_press_cin cyc=%0d got=%b want=0", cyc, cin);
      else n_pass++;
      if (cyc == 7) begin
        n_checks++;
        if (key_level !== 1'b1) $display("FAIL hold_press_level got=%b want=1", key_level);
        else n_pass++;
      end
    end
    settle_release();
  endtask

  // auto_en dropped so the prescaler is cleared at 3, restored at cyc 14;
  // then a press completes at cyc 33 in auto mode and yields no extra cin.
  task automatic test_mode_switch();
    logic exp_cin;
    apply_reset(1'b1);
    for (int cyc = 1; cyc <= 40; cyc++) begin
      auto_en = !(cyc >= 9 && cyc <= 13);
      key_n   = !(cyc >= 27);
      tick();
      exp_cin = (cyc == 7) || (cyc >= 20 && ((cyc - 20) % 5) == 0);
      n_checks++;
      if (cin !== exp_cin) $display("FAIL mode_cin cyc=%0d got=%b want=%b", cyc, cin, exp_cin);
      else n_pass++;
      if (cyc == 33) begin
        n_checks++;
        if (key_level !== 1'b1) $display("FAIL mode_press_level got=%b want=1", key_level);
        else n_pass++;
      end
    end
    settle_release();
  endtask

  // Async reset mid-debounce, button kept low: full debounce again.
  task automatic test_async_reset();
    apply_reset(1'b0);
    for (int cyc = 1; cyc <= 5; cyc++) begin
      key_n = 1'b0;
      tick();
    end
    n_checks++;
    if (dbg_state !== ST_PRESS_WAIT) $display("FAIL ar_state_before got=%0d want=%0d", dbg_state, ST_PRESS_WAIT);
    else n_pass++;
    #1;
    rst_n = 1'b0;
    #1;
    n_checks++;
    if (cin !== 1'b0 || key_level !== 1'b0) $display("FAIL ar_outputs got=%b%b want=00", cin, key_level);
    else n_pass++;
    n_checks++;
    if (dbg_state !== ST_IDLE) $display("FAIL ar_state got=%0d want=%0d", dbg_state, ST_IDLE);
    else n_pass++;
    #1;
    rst_n = 1'b1;
    for (int cyc = 1; cyc <= 12; cyc++) begin
      tick();
      n_checks++;
      if (cin !== (cyc == 7)) $display("FAIL ar_cin cyc=%0d got=%b want=%b", cyc, cin, (cyc == 7));
      else n_pass++;
      if (cyc == 7) begin
        n_checks++;
        if (key_level !== 1'b1) $display("FAIL ar_level got=%b want=1", key_level);
        else n_pass++;
      end
    end
    settle_release();
  endtask

  initial begin
    n_checks = 0;
    n_pass   = 0;
    rst_n    = 1'b0;
    key_n    = 1'b1;
    auto_en  = 1'b0;
    hold     = 1'b0;
    test_reset();
    test_clean_press();
    test_bounce();
    test_hold();
    test_hold_press();
    test_mode_switch();
    test_async_reset();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
